// File: rtl/io_controller_pkg.sv
// Shared constants, drive-source encoding and address decode helper for the I/O controller.
package io_controller_pkg;

  localparam int          DATA_W       = 16;
  localparam int          N_DEV        = 15;
  localparam int          ADDR_W       = 4;
  localparam logic [3:0]  CTL_ADDR     = 4'hF;
  localparam logic [15:0] HANDLER_ADDR = 16'h0100;

  // Who owns d_bus this cycle; listed from highest to lowest priority.
  typedef enum logic [1:0] {
    DRV_NONE    = 2'd0,
    DRV_PUSH    = 2'd1,
    DRV_INTS    = 2'd2,
    DRV_RETADDR = 2'd3
  } drv_sel_e;

  // One-hot device select; CTL_ADDR shifts the bit out, so it selects no device.
  function automatic logic [N_DEV-1:0] dev_onehot(input logic [ADDR_W-1:0] addr);
    dev_onehot = {{(N_DEV-1){1'b0}}, 1'b1} << addr;
  endfunction

endpackage

// File: rtl/io_controller_if.sv
// CPU-side strobe bundle between the control unit (master) and the I/O controller (slave).
// Strobes are level signals sampled at posedge clk; there is no backpressure. Drive strobes
// (io_push, io_ints, io_read_retaddr) act combinationally on d_bus, all others take effect
// at the next edge. io_read/io_write only count while io_addr_read qualifies io_addr.
interface io_controller_if;
  import io_controller_pkg::*;

  logic [ADDR_W-1:0] io_addr;
  logic              io_addr_read;
  logic              io_read;
  logic              io_push;
  logic              io_write;
  logic              io_ints;
  logic              io_store_retaddr;
  logic              io_read_retaddr;
  logic              irq_req;
  logic [DATA_W-1:0] irq_handler;
  logic              bus_conflict;

  modport master (
    output io_addr, io_addr_read, io_read, io_push, io_write, io_ints,
           io_store_retaddr, io_read_retaddr,
    input  irq_req, irq_handler, bus_conflict
  );

  modport slave (
    input  io_addr, io_addr_read, io_read, io_push, io_write, io_ints,
           io_store_retaddr, io_read_retaddr,
    output irq_req, irq_handler, bus_conflict
  );

endinterface

// File: rtl/io_controller_irq_ctrl.sv
// Interrupt state: rising-edge detect on device request lines, pending/mask registers,
// global enable and the registered request to the control unit.
module io_controller_irq_ctrl
  import io_controller_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_DEV-1:0] dev_irq,
  input  logic [N_DEV-1:0] pend_clr,
  input  logic             mask_we,
  input  logic [N_DEV-1:0] mask_wdata,
  input  logic             int_en_set,
  input  logic             int_en_clr,
  output logic [N_DEV-1:0] mask,
  output logic [N_DEV-1:0] pending,
  output logic             irq_req
);

  logic [N_DEV-1:0] irq_hist;
  logic [N_DEV-1:0] pending_nxt;
  logic [N_DEV-1:0] mask_nxt;
  logic             int_en;
  logic             int_en_nxt;

  // Next-state: a new edge beats a same-cycle clear; disabling beats enabling.
  always_comb begin
    pending_nxt = (pending & ~pend_clr) | (dev_irq & ~irq_hist);
    mask_nxt    = mask_we ? mask_wdata : mask;
    int_en_nxt  = int_en;
    if (int_en_set) int_en_nxt = 1'b1;
    if (int_en_clr) int_en_nxt = 1'b0;
  end

  // Register update; irq_req follows the new state so it moves one edge after its cause.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_hist <= '0;
      pending  <= '0;
      mask     <= '0;
      int_en   <= 1'b0;
      irq_req  <= 1'b0;
    end else begin
      irq_hist <= dev_irq;
      pending  <= pending_nxt;
      mask     <= mask_nxt;
      int_en   <= int_en_nxt;
      irq_req  <= int_en_nxt & (|(pending_nxt & mask_nxt));
    end
  end

endmodule

// File: rtl/io_controller.sv
// Responder side of the CPU I/O bus: address decode, device read/write registers,
// return-address register and the tri-state d_bus driver.
module io_controller
  import io_controller_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  io_controller_if.slave          bus,
  inout  wire  [DATA_W-1:0]       d_bus,
  input  logic [N_DEV*DATA_W-1:0] dev_in,
  input  logic [N_DEV-1:0]        dev_rx_valid,
  output logic [N_DEV-1:0]        dev_rx_ack,
  output logic [N_DEV*DATA_W-1:0] dev_out,
  output logic [N_DEV-1:0]        dev_tx_strobe,
  input  logic [N_DEV-1:0]        dev_irq
);

  logic              rd_en;
  logic              wr_en;
  logic              is_ctl;
  logic [N_DEV-1:0]  sel;
  logic [DATA_W-1:0] dev_word;
  logic [DATA_W-1:0] read_buf;
  logic [DATA_W-1:0] retaddr;
  logic [N_DEV-1:0]  mask;
  logic [N_DEV-1:0]  pending;
  drv_sel_e          drv_sel;
  logic              conflict;
  logic              conflict_q;
  logic              d_bus_oe;
  logic [DATA_W-1:0] d_bus_val;

  assign rd_en  = bus.io_read  & bus.io_addr_read;
  assign wr_en  = bus.io_write & bus.io_addr_read;
  assign is_ctl = (bus.io_addr == CTL_ADDR);
  assign sel    = dev_onehot(bus.io_addr);

  // Select the addressed device's input word.
  always_comb begin
    dev_word = '0;
    for (int k = 0; k < N_DEV; k++) begin
      if (sel[k]) dev_word = dev_in[k*DATA_W +: DATA_W];
    end
  end

  // Pick the single bus owner by priority and flag simultaneous drive requests.
  always_comb begin
    drv_sel   = DRV_NONE;
    d_bus_val = '0;
    if (bus.io_push)              drv_sel = DRV_PUSH;
    else if (bus.io_ints)         drv_sel = DRV_INTS;
    else if (bus.io_read_retaddr) drv_sel = DRV_RETADDR;
    case (drv_sel)
      DRV_PUSH:    d_bus_val = read_buf;
      DRV_INTS:    d_bus_val = DATA_W'(pending & mask);
      DRV_RETADDR: d_bus_val = retaddr;
      default:     d_bus_val = '0;
    endcase
    conflict = (bus.io_push & bus.io_ints) | (bus.io_push & bus.io_read_retaddr) |
               (bus.io_ints & bus.io_read_retaddr);
    d_bus_oe = rst_n && (drv_sel != DRV_NONE);
  end

  assign d_bus = d_bus_oe ? d_bus_val : {DATA_W{1'bz}};

  // Transfer registers and one-cycle acknowledge/strobe/conflict pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_buf      <= '0;
      retaddr       <= '0;
      dev_out       <= '0;
      dev_rx_ack    <= '0;
      dev_tx_strobe <= '0;
      conflict_q    <= 1'b0;
    end else begin
      dev_rx_ack    <= rd_en ? (sel & dev_rx_valid) : '0;
      dev_tx_strobe <= wr_en ? sel : '0;
      conflict_q    <= conflict;
      if (rd_en) read_buf <= is_ctl ? DATA_W'(mask) : dev_word;
      if (bus.io_store_retaddr) retaddr <= d_bus;
      for (int k = 0; k < N_DEV; k++) begin
        if (wr_en && sel[k]) dev_out[k*DATA_W +: DATA_W] <= d_bus;
      end
    end
  end

  assign bus.bus_conflict = conflict_q;
  assign bus.irq_handler  = HANDLER_ADDR;

  io_controller_irq_ctrl u_irq (
    .clk        (clk),
    .rst_n      (rst_n),
    .dev_irq    (dev_irq),
    .pend_clr   (rd_en ? sel : {N_DEV{1'b0}}),
    .mask_we    (wr_en & is_ctl),
    .mask_wdata (d_bus[N_DEV-1:0]),
    .int_en_set (bus.io_read_retaddr),
    .int_en_clr (bus.io_store_retaddr),
    .mask       (mask),
    .pending    (pending),
    .irq_req    (bus.irq_req)
  );

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller: reset, device write/read, interrupt flow, masking,
// set-versus-clear priority, drive conflict and reset during a transfer.
module tb_io_controller;
  import io_controller_pkg::*;

  logic                    clk;
  logic                    rst_n;
  logic [N_DEV*DATA_W-1:0] dev_in;
  logic [N_DEV-1:0]        dev_rx_valid;
  logic [N_DEV-1:0]        dev_rx_ack;
  logic [N_DEV*DATA_W-1:0] dev_out;
  logic [N_DEV-1:0]        dev_tx_strobe;
  logic [N_DEV-1:0]        dev_irq;
  logic                    tb_oe;
  logic [DATA_W-1:0]       tb_val;
  wire  [DATA_W-1:0]       d_bus;

  int errors = 0;
  int checks = 0;

  io_controller_if bus ();

  assign d_bus = tb_oe ? tb_val : {DATA_W{1'bz}};

  io_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .d_bus         (d_bus),
    .dev_in        (dev_in),
    .dev_rx_valid  (dev_rx_valid),
    .dev_rx_ack    (dev_rx_ack),
    .dev_out       (dev_out),
    .dev_tx_strobe (dev_tx_strobe),
    .dev_irq       (dev_irq)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.io_addr          = 4'h0;
    bus.io_addr_read     = 1'b0;
    bus.io_read          = 1'b0;
    bus.io_push          = 1'b0;
    bus.io_write         = 1'b0;
    bus.io_ints          = 1'b0;
    bus.io_store_retaddr = 1'b0;
    bus.io_read_retaddr  = 1'b0;
    tb_oe                = 1'b0;
    tb_val               = '0;
  endtask

  task automatic drive_write(input logic [3:0] addr, input logic [15:0] val);
    idle();
    bus.io_addr      = addr;
    bus.io_addr_read = 1'b1;
    bus.io_write     = 1'b1;
    tb_oe            = 1'b1;
    tb_val           = val;
  endtask

  task automatic drive_read(input logic [3:0] addr);
    idle();
    bus.io_addr      = addr;
    bus.io_addr_read = 1'b1;
    bus.io_read      = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    for (int k = 0; k < N_DEV; k++) dev_in[k*DATA_W +: DATA_W] = 16'h1000 + 16'(k);
    dev_in[5*DATA_W +: DATA_W] = 16'h1234;
    dev_rx_valid = 15'h0020;
    dev_irq      = '0;

    // Reset with a drive strobe held high
    bus.io_push = 1'b1;
    repeat (3) step();
    check("rst_bus_released", dut.d_bus_oe, 0);
    check("rst_irq_req", bus.irq_req, 0);
    check("rst_rx_ack", dev_rx_ack, 0);
    check("rst_tx_strobe", dev_tx_strobe, 0);
    check("rst_conflict", bus.bus_conflict, 0);
    check("rst_dev_out", |dev_out, 0);
    check("irq_handler", bus.irq_handler, 16'h0100);
    idle();
    rst_n = 1'b1;
    step();
    check("post_rst_irq_req", bus.irq_req, 0);
    bus.io_push = 1'b1;
    #1;
    check("post_rst_push", d_bus, 16'h0000);
    step();
    idle();

    // Write device 3
    drive_write(4'd3, 16'hBEEF);
    step();
    check("wr3_dev_out", dev_out[3*DATA_W +: DATA_W], 16'hBEEF);
    check("wr3_strobe", dev_tx_strobe, 15'h0008);
    idle();
    step();
    check("wr3_strobe_drop", dev_tx_strobe, 15'h0000);

    // Write without io_addr_read is ignored
    drive_write(4'd4, 16'h5555);
    bus.io_addr_read = 1'b0;
    step();
    check("wr_noaddr_dev_out", dev_out[4*DATA_W +: DATA_W], 16'h0000);
    check("wr_noaddr_strobe", dev_tx_strobe, 15'h0000);
    idle();

    // Read device 5 with fresh data
    drive_read(4'd5);
    step();
    check("rd5_ack", dev_rx_ack, 15'h0020);
    idle();
    bus.io_push = 1'b1;
    #1;
    check("rd5_push", d_bus, 16'h1234);
    step();
    check("rd5_ack_drop", dev_rx_ack, 15'h0000);
    idle();

    // Read device 6 without rx_valid: no ack
    drive_read(4'd6);
    step();
    check("rd6_no_ack", dev_rx_ack, 15'h0000);
    idle();
    bus.io_push = 1'b1;
    #1;
    check("rd6_push", d_bus, 16'h1006);
    step();
    idle();

    // Mask via control register, read it back
    drive_write(CTL_ADDR, 16'h0004);
    step();
    check("ctl_wr_no_strobe", dev_tx_strobe, 15'h0000);
    drive_read(CTL_ADDR);
    step();
    check("ctl_rd_no_ack", dev_rx_ack, 15'h0000);
    idle();
    bus.io_push = 1'b1;
    #1;
    check("ctl_readback", d_bus, 16'h0004);
    step();
    idle();

    // Enable interrupts, raise device 2
    bus.io_read_retaddr = 1'b1;
    #1;
    check("retaddr_initial", d_bus, 16'h0000);
    step();
    idle();
    check("irq_idle", bus.irq_req, 0);
    dev_irq[2] = 1'b1;
    step();
    check("irq_rise", bus.irq_req, 1);
    bus.io_ints = 1'b1;
    #1;
    check("ints_vec", d_bus, 16'h0004);
    step();
    idle();
    check("ints_keeps_pending", bus.irq_req, 1);
    tb_oe = 1'b1;
    tb_val = 16'h0042;
    bus.io_store_retaddr = 1'b1;
    step();
    check("store_ret_disables", bus.irq_req, 0);
    idle();
    bus.io_read_retaddr = 1'b1;
    #1;
    check("retaddr_readback", d_bus, 16'h0042);
    step();
    idle();
    check("read_ret_enables", bus.irq_req, 1);
    drive_read(4'd2);
    step();
    check("read_clears_pending", bus.irq_req, 0);
    idle();

    // Masked request on device 7
    drive_write(CTL_ADDR, 16'h0000);
    step();
    idle();
    dev_irq[7] = 1'b1;
    step();
    check("masked_no_irq", bus.irq_req, 0);
    bus.io_ints = 1'b1;
    #1;
    check("masked_ints_vec", d_bus, 16'h0000);
    step();
    drive_write(CTL_ADDR, 16'h0080);
    step();
    check("unmask_irq", bus.irq_req, 1);
    idle();

    // Same-cycle set and clear of pending[7]: set wins
    drive_read(4'd7);
    step();
    check("rd7_clears", bus.irq_req, 0);
    idle();
    dev_irq[7] = 1'b0;
    step();
    dev_irq[7] = 1'b1;
    drive_read(4'd7);
    step();
    check("set_wins", bus.irq_req, 1);
    idle();
    bus.io_ints = 1'b1;
    #1;
    check("set_wins_vec", d_bus, 16'h0080);
    step();
    idle();

    // Drive conflict: push beats ints
    bus.io_push = 1'b1;
    bus.io_ints = 1'b1;
    #1;
    check("conflict_winner", d_bus, 16'h1007);
    step();
    check("conflict_pulse", bus.bus_conflict, 1);
    idle();
    step();
    check("conflict_drop", bus.bus_conflict, 0);
    check("idle_released", dut.d_bus_oe, 0);

    // Reset during a write: nothing emitted
    drive_write(4'd3, 16'h7777);
    rst_n = 1'b0;
    step();
    check("rst_mid_strobe", dev_tx_strobe, 15'h0000);
    check("rst_mid_dev_out", dev_out[3*DATA_W +: DATA_W], 16'h0000);
    idle();
    rst_n = 1'b1;
    step();
    check("rst_mid_after", dev_tx_strobe, 15'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
